// File: rtl/lycan_usb_bus_arbiter.sv
// Half-duplex owner of the shared FT601-style USB FIFO bus. It alternates between
// draining the USB chip into the RX FIFO and draining the FWFT TX FIFO into the chip.
module lycan_usb_bus_arbiter #(
    parameter int unsigned MAX_BURST = 64,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic [31:0]      usb_data_i,
    input  logic [3:0]       usb_be_i,
    output logic [31:0]      usb_data_o,
    output logic [3:0]       usb_be_o,
    output logic             usb_bus_oe,
    input  logic             usb_rx_empty,
    input  logic             usb_tx_full,
    output logic             usb_outen_l,
    output logic             usb_rden_l,
    output logic             usb_wren_l,
    output logic [31:0]      rx_data,
    output logic [3:0]       rx_be,
    output logic             rx_wren,
    input  logic             rx_afull,
    input  logic [31:0]      tx_data,
    input  logic [3:0]       tx_be,
    input  logic             tx_empty,
    output logic             tx_rden,
    output logic             busy,
    output logic [CNT_W-1:0] rx_count,
    output logic [CNT_W-1:0] tx_count
);

    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_OE,
        S_RX_READ,
        S_TX_WRITE,
        S_TURN
    } state_e;

    typedef enum logic {
        DIR_RX,
        DIR_TX
    } dir_e;

    state_e             state_q, state_d;
    dir_e               last_grant_q, last_grant_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [31:0]        rx_data_q;
    logic [3:0]         rx_be_q;
    logic               rx_wren_q;
    logic [CNT_W-1:0]   rx_count_q;
    logic [CNT_W-1:0]   tx_count_q;
    logic               outen_l_q;
    logic               busy_q;

    logic               rx_req;
    logic               tx_req;
    logic               rx_beat;
    logic               tx_beat;
    logic [BURST_W-1:0] burst_inc;
    logic               burst_last;

    assign rx_req     = !usb_rx_empty && !rx_afull;
    assign tx_req     = !tx_empty && !usb_tx_full;
    assign rx_beat    = (state_q == S_RX_READ) && rx_req;
    assign tx_beat    = (state_q == S_TX_WRITE) && tx_req;
    assign burst_inc  = burst_q + BURST_W'(1);
    assign burst_last = (burst_inc == BURST_W'(MAX_BURST));

    // Next-state, grant and burst bookkeeping; a burst ends on the first stall cycle.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        burst_d      = burst_q;
        case (state_q)
            S_IDLE: begin
                burst_d = '0;
                if (rx_req && (!tx_req || (last_grant_q == DIR_TX))) begin
                    state_d      = S_RX_OE;
                    last_grant_d = DIR_RX;
                end else if (tx_req) begin
                    state_d      = S_TX_WRITE;
                    last_grant_d = DIR_TX;
                end
            end
            S_RX_OE: begin
                state_d = S_RX_READ;
            end
            S_RX_READ: begin
                if (!rx_req) begin
                    state_d = S_TURN;
                end else begin
                    burst_d = burst_inc;
                    if (burst_last) begin
                        state_d = S_TURN;
                    end
                end
            end
            S_TX_WRITE: begin
                if (!tx_req) begin
                    state_d = S_TURN;
                end else begin
                    burst_d = burst_inc;
                    if (burst_last) begin
                        state_d = S_TURN;
                    end
                end
            end
            S_TURN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q      <= S_IDLE;
            last_grant_q <= DIR_TX;
            burst_q      <= '0;
            rx_data_q    <= '0;
            rx_be_q      <= '0;
            rx_wren_q    <= 1'b0;
            rx_count_q   <= '0;
            tx_count_q   <= '0;
            outen_l_q    <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            burst_q      <= burst_d;
            rx_wren_q    <= rx_beat;
            // Chip output enable follows the RX phases; never overlaps the TX bus drive.
            outen_l_q    <= !((state_d == S_RX_OE) || (state_d == S_RX_READ));
            busy_q       <= (state_d != S_IDLE);
            if (rx_beat) begin
                rx_data_q  <= usb_data_i;
                rx_be_q    <= usb_be_i;
                rx_count_q <= rx_count_q + CNT_W'(1);
            end
            if (tx_beat) begin
                tx_count_q <= tx_count_q + CNT_W'(1);
            end
        end
    end

    // Strobes are combinational so a request drop stops the transfer in the same cycle.
    assign usb_rden_l  = !rx_beat;
    assign usb_wren_l  = !tx_beat;
    assign tx_rden     = tx_beat;
    assign usb_bus_oe  = (state_q == S_TX_WRITE);
    assign usb_data_o  = usb_bus_oe ? tx_data : 32'd0;
    assign usb_be_o    = usb_bus_oe ? tx_be : 4'd0;

    assign usb_outen_l = outen_l_q;
    assign busy        = busy_q;
    assign rx_data     = rx_data_q;
    assign rx_be       = rx_be_q;
    assign rx_wren     = rx_wren_q;
    assign rx_count    = rx_count_q;
    assign tx_count    = tx_count_q;

endmodule

// File: tb/tb_lycan_usb_bus_arbiter.sv
// Bench for lycan_usb_bus_arbiter: bench-side USB chip and TX FIFO models, a table of
// whole-transfer vectors, and hand-written sequences for the multi-cycle corners.
module tb_lycan_usb_bus_arbiter;

    localparam int unsigned MAX_BURST = 4;
    localparam int unsigned CNT_W     = 4;
    localparam int          NVEC      = 8;

    logic             clk          = 1'b0;
    logic             rst_l        = 1'b0;
    logic [31:0]      usb_data_i   = '0;
    logic [3:0]       usb_be_i     = '0;
    logic [31:0]      usb_data_o;
    logic [3:0]       usb_be_o;
    logic             usb_bus_oe;
    logic             usb_rx_empty = 1'b1;
    logic             usb_tx_full  = 1'b0;
    logic             usb_outen_l;
    logic             usb_rden_l;
    logic             usb_wren_l;
    logic [31:0]      rx_data;
    logic [3:0]       rx_be;
    logic             rx_wren;
    logic             rx_afull     = 1'b0;
    logic [31:0]      tx_data      = '0;
    logic [3:0]       tx_be        = '0;
    logic             tx_empty     = 1'b1;
    logic             tx_rden;
    logic             busy;
    logic [CNT_W-1:0] rx_count;
    logic [CNT_W-1:0] tx_count;

    lycan_usb_bus_arbiter #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .usb_data_i   (usb_data_i),
        .usb_be_i     (usb_be_i),
        .usb_data_o   (usb_data_o),
        .usb_be_o     (usb_be_o),
        .usb_bus_oe   (usb_bus_oe),
        .usb_rx_empty (usb_rx_empty),
        .usb_tx_full  (usb_tx_full),
        .usb_outen_l  (usb_outen_l),
        .usb_rden_l   (usb_rden_l),
        .usb_wren_l   (usb_wren_l),
        .rx_data      (rx_data),
        .rx_be        (rx_be),
        .rx_wren      (rx_wren),
        .rx_afull     (rx_afull),
        .tx_data      (tx_data),
        .tx_be        (tx_be),
        .tx_empty     (tx_empty),
        .tx_rden      (tx_rden),
        .busy         (busy),
        .rx_count     (rx_count),
        .tx_count     (tx_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n_rx;
        int n_tx;
        bit afull;
        bit txfull;
        int exp_rx_cnt;
        int exp_tx_cnt;
        int exp_first;   // 0 none, 1 RX, 2 TX
    } vec_t;

    vec_t vecs [NVEC];

    int n_cmp = 0;
    int n_bad = 0;

    // Chip / FIFO model state: word i of each stream is generated from its index.
    int rx_next = 0, rx_limit = 0, tx_next = 0, tx_limit = 0;
    int rx_beats = 0, tx_beats = 0, rx_wrens = 0;
    int rx_exp[$];
    int beat_dir[$];
    int gap_en = 0, prev_dir = 0, idle_run = 0, n_turns = 0;
    logic snap_outen_l, snap_rden_l, snap_wren_l, snap_oe;
    int base, base_w, base_b, got_first, found, w;

    function automatic logic [31:0] rx_word(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction
    function automatic logic [3:0] rx_be_of(input int i);
        return 4'(i);
    endfunction
    function automatic logic [31:0] tx_word(input int i);
        return 32'h5A00_0000 | 32'(i * 3);
    endfunction
    function automatic logic [3:0] tx_be_of(input int i);
        return ~4'(i);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive();
        usb_rx_empty = (rx_next >= rx_limit);
        usb_data_i   = rx_word(rx_next);
        usb_be_i     = rx_be_of(rx_next);
        tx_empty     = (tx_next >= tx_limit);
        tx_data      = tx_word(tx_next);
        tx_be        = tx_be_of(tx_next);
    endtask

    // One clock: drive inputs, judge strobes at negedge, apply chip/FIFO pops after posedge.
    task automatic tick();
        logic rb, tb;
        int   act;
        int   idx;
        drive();
        @(negedge clk);
        snap_outen_l = usb_outen_l;
        snap_rden_l  = usb_rden_l;
        snap_wren_l  = usb_wren_l;
        snap_oe      = usb_bus_oe;
        rb = !usb_rden_l && !usb_rx_empty;
        tb = !usb_wren_l;
        check("outen_oe_overlap", 32'(!usb_outen_l && usb_bus_oe), 32'd0);
        check("tx_rden_wren_pair", 32'(tx_rden ^ !usb_wren_l), 32'd0);
        check("wren_rule", 32'(!usb_wren_l), 32'(usb_bus_oe && !tx_empty && !usb_tx_full));
        check("rden_rule", 32'(!usb_rden_l && (usb_outen_l || usb_rx_empty || rx_afull)), 32'd0);
        if (tb) begin
            check("usb_data_o", usb_data_o, tx_word(tx_next));
            check("usb_be_o", 32'(usb_be_o), 32'(tx_be_of(tx_next)));
        end
        if (!usb_bus_oe) begin
            check("idle_bus_drive", usb_data_o | 32'(usb_be_o), 32'd0);
        end
        act = !usb_outen_l ? 1 : (usb_bus_oe ? 2 : 0);
        if (act != 0) begin
            if (gap_en != 0 && prev_dir != 0 && act != prev_dir) begin
                n_turns++;
                check("turn_gap", 32'(idle_run), 32'd2);
            end
            prev_dir = act;
            idle_run = 0;
        end else begin
            idle_run++;
        end
        @(posedge clk);
        #1;
        if (rb) begin
            rx_exp.push_back(rx_next);
            rx_next++;
            rx_beats++;
            beat_dir.push_back(1);
        end
        if (tb) begin
            tx_next++;
            tx_beats++;
            beat_dir.push_back(2);
        end
        if (rx_wren) begin
            rx_wrens++;
            if (rx_exp.size() == 0) begin
                check("rx_wren_phantom", 32'(rx_wren), 32'd0);
            end else begin
                idx = rx_exp.pop_front();
                check("rx_data", rx_data, rx_word(idx));
                check("rx_be", 32'(rx_be), 32'(rx_be_of(idx)));
            end
        end
    endtask

    task automatic do_reset();
        rx_afull    = 1'b0;
        usb_tx_full = 1'b0;
        rx_limit    = rx_next;
        tx_limit    = tx_next;
        rst_l       = 1'b0;
        tick();
        tick();
        rst_l       = 1'b1;
        rx_exp.delete();
        prev_dir    = 0;
        idle_run    = 0;
    endtask

    initial begin
        vecs[0] = '{8,  0,  1'b0, 1'b0, 8, 0, 1};
        vecs[1] = '{0,  5,  1'b0, 1'b0, 0, 5, 2};
        vecs[2] = '{3,  3,  1'b0, 1'b0, 3, 3, 1};
        vecs[3] = '{5,  0,  1'b1, 1'b0, 0, 0, 0};
        vecs[4] = '{0,  5,  1'b0, 1'b1, 0, 0, 0};
        vecs[5] = '{17, 0,  1'b0, 1'b0, 1, 0, 1};
        vecs[6] = '{6,  6,  1'b0, 1'b0, 6, 6, 1};
        vecs[7] = '{0,  20, 1'b0, 1'b0, 0, 4, 2};

        // Reset state
        do_reset();
        check("rst_outen_l", 32'(usb_outen_l), 32'd1);
        check("rst_rden_l", 32'(usb_rden_l), 32'd1);
        check("rst_wren_l", 32'(usb_wren_l), 32'd1);
        check("rst_bus_oe", 32'(usb_bus_oe), 32'd0);
        check("rst_rx_wren", 32'(rx_wren), 32'd0);
        check("rst_tx_rden", 32'(tx_rden), 32'd0);
        check("rst_rx_data", rx_data, 32'd0);
        check("rst_rx_be", 32'(rx_be), 32'd0);
        check("rst_rx_count", 32'(rx_count), 32'd0);
        check("rst_tx_count", 32'(tx_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Table of whole transfers from reset
        for (int v = 0; v < NVEC; v++) begin
            do_reset();
            rx_afull    = vecs[v].afull;
            usb_tx_full = vecs[v].txfull;
            rx_limit    = rx_next + vecs[v].n_rx;
            tx_limit    = tx_next + vecs[v].n_tx;
            base        = beat_dir.size();
            repeat (80) tick();
            got_first = (beat_dir.size() > base) ? beat_dir[base] : 0;
            check($sformatf("vec%0d_rx_count", v), 32'(rx_count), 32'(vecs[v].exp_rx_cnt));
            check($sformatf("vec%0d_tx_count", v), 32'(tx_count), 32'(vecs[v].exp_tx_cnt));
            check($sformatf("vec%0d_first_dir", v), 32'(got_first), 32'(vecs[v].exp_first));
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
        end

        // RX entry: output enable one cycle ahead of the read strobe
        do_reset();
        rx_limit = rx_next + 8;
        base_w   = rx_wrens;
        found    = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            tick();
            if (!snap_outen_l) found = 1;
        end
        check("t1_outen_seen", 32'(found), 32'd1);
        if (found != 0) begin
            check("t1_rden_in_rx_oe", 32'(snap_rden_l), 32'd1);
            tick();
            check("t1_outen_held", 32'(snap_outen_l), 32'd0);
            check("t1_rden_after_oe", 32'(snap_rden_l), 32'd0);
        end
        repeat (60) tick();
        check("t1_rx_count", 32'(rx_count), 32'd8);
        check("t1_rx_wrens", 32'(rx_wrens - base_w), 32'd8);
        check("t1_busy", 32'(busy), 32'd0);

        // Both directions pending: RX4, TX4 alternation with a turnaround on each switch
        do_reset();
        rx_limit = rx_next + 12;
        tx_limit = tx_next + 12;
        base     = beat_dir.size();
        n_turns  = 0;
        gap_en   = 1;
        repeat (100) tick();
        gap_en   = 0;
        check("t2_beats", 32'(beat_dir.size() - base), 32'd24);
        check("t2_turns", 32'(n_turns), 32'd5);
        for (int i = 0; i < 24; i++) begin
            if (base + i < beat_dir.size()) begin
                check($sformatf("t2_beat%0d_dir", i), 32'(beat_dir[base + i]), ((i / 4) % 2 == 0) ? 32'd1 : 32'd2);
            end
        end

        // TX stall after two beats ends the burst, then regrant finishes the words
        do_reset();
        tx_limit = tx_next + 5;
        base_b   = tx_beats;
        w        = 0;
        while ((tx_beats - base_b) < 2 && w < 20) begin
            tick();
            w++;
        end
        check("t3_two_beats", 32'(tx_beats - base_b), 32'd2);
        usb_tx_full = 1'b1;
        tick();
        check("t3_wren_blocked", 32'(snap_wren_l), 32'd1);
        tick();
        check("t3_burst_ended", 32'(snap_oe), 32'd0);
        usb_tx_full = 1'b0;
        repeat (30) tick();
        check("t3_tx_count", 32'(tx_count), 32'd5);
        check("t3_tx_beats", 32'(tx_beats - base_b), 32'd5);

        // RX FIFO almost-full after beat 3 stops reads the next cycle
        do_reset();
        rx_limit = rx_next + 10;
        base_b   = rx_beats;
        base_w   = rx_wrens;
        w        = 0;
        while ((rx_beats - base_b) < 3 && w < 20) begin
            tick();
            w++;
        end
        check("t4_three_beats", 32'(rx_beats - base_b), 32'd3);
        rx_afull = 1'b1;
        tick();
        check("t4_rden_stops", 32'(snap_rden_l), 32'd1);
        repeat (4) tick();
        check("t4_beats_held", 32'(rx_beats - base_b), 32'd3);
        check("t4_wrens_held", 32'(rx_wrens - base_w), 32'd3);
        rx_afull = 1'b0;
        repeat (60) tick();
        check("t4_rx_count", 32'(rx_count), 32'd10);
        check("t4_rx_wrens", 32'(rx_wrens - base_w), 32'd10);

        // One-cycle reset in the middle of a TX burst
        do_reset();
        tx_limit = tx_next + 8;
        base_b   = tx_beats;
        w        = 0;
        while ((tx_beats - base_b) < 2 && w < 20) begin
            tick();
            w++;
        end
        check("t5_tx_count_pre", 32'(tx_count), 32'd2);
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
        check("t5_wren_l", 32'(usb_wren_l), 32'd1);
        check("t5_tx_rden", 32'(tx_rden), 32'd0);
        check("t5_bus_oe", 32'(usb_bus_oe), 32'd0);
        check("t5_outen_l", 32'(usb_outen_l), 32'd1);
        check("t5_rden_l", 32'(usb_rden_l), 32'd1);
        check("t5_tx_count", 32'(tx_count), 32'd0);
        check("t5_rx_count", 32'(rx_count), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
